// File: rtl/sdram_cmd_arbiter_pkg.sv
// Shared encodings, FSM states and width helpers for the SDRAM command arbiter.
package sdram_pkg;

  localparam int CMD_W = 4;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_ACT  = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_WR   = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_RD   = 4'b0101;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_ARBIT = 2'd1,
    ST_AREF  = 2'd2,
    ST_GRANT = 2'd3
  } arb_state_t;

  // Width of a channel index; a single channel still gets one bit.
  function automatic int gid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One mask bit per data byte.
  function automatic int dqm_w(input int dq_w);
    return dq_w / 8;
  endfunction

endpackage

// File: rtl/sdram_cmd_arbiter_if.sv
// Bundle of sequencer, refresh, client and SDRAM pin signals around the arbiter.
interface sdram_cmd_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 12,
  parameter int BA_W   = 2,
  parameter int DQ_W   = 16
);
  import sdram_pkg::*;

  localparam int GID_W = gid_w(NUM_CH);

  logic                               init_done;
  logic [CMD_W-1:0]                   init_cmd;
  logic [ADDR_W-1:0]                  init_addr;

  logic                               ref_req;
  logic                               ref_en;
  logic                               ref_end;
  logic [CMD_W-1:0]                   ref_cmd;
  logic [ADDR_W-1:0]                  ref_addr;

  logic [NUM_CH-1:0]                  ch_req;
  logic [NUM_CH-1:0]                  ch_en;
  logic [NUM_CH-1:0]                  ch_end;
  logic [NUM_CH-1:0][CMD_W-1:0]       ch_cmd;
  logic [NUM_CH-1:0][ADDR_W-1:0]      ch_addr;
  logic [NUM_CH-1:0][BA_W-1:0]        ch_bank;
  logic [NUM_CH-1:0][DQ_W-1:0]        ch_wdata;
  logic [NUM_CH-1:0]                  ch_dq_oe;

  logic [CMD_W-1:0]                   sdram_cmd;
  logic [ADDR_W-1:0]                  sdram_addr;
  logic [BA_W-1:0]                    sdram_bank;
  logic [DQ_W-1:0]                    sdram_dq_out;
  logic                               sdram_dq_oe;
  logic [dqm_w(DQ_W)-1:0]             sdram_dqm;

  logic [GID_W-1:0]                   grant_id;
  logic                               busy;
  logic                               timeout_err;

  // Arbiter side
  modport master (
    input  init_done, init_cmd, init_addr,
    input  ref_req, ref_end, ref_cmd, ref_addr,
    input  ch_req, ch_end, ch_cmd, ch_addr, ch_bank, ch_wdata, ch_dq_oe,
    output ref_en, ch_en,
    output sdram_cmd, sdram_addr, sdram_bank, sdram_dq_out, sdram_dq_oe, sdram_dqm,
    output grant_id, busy, timeout_err
  );

  // Sequencer / engine / pin side
  modport slave (
    output init_done, init_cmd, init_addr,
    output ref_req, ref_end, ref_cmd, ref_addr,
    output ch_req, ch_end, ch_cmd, ch_addr, ch_bank, ch_wdata, ch_dq_oe,
    input  ref_en, ch_en,
    input  sdram_cmd, sdram_addr, sdram_bank, sdram_dq_out, sdram_dq_oe, sdram_dqm,
    input  grant_id, busy, timeout_err
  );

endinterface

// File: rtl/sdram_cmd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module sdram_rr_pick
  import sdram_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = gid_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          vld,
  output logic [IW-1:0] idx
);

  // Scan offsets from far to near so the nearest requester is written last.
  always_comb begin
    int j;
    j   = 0;
    vld = 1'b0;
    idx = ptr;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        vld = 1'b1;
        idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command arbiter: init -> refresh/client ownership with round-robin,
// grant watchdog and a combinational pin mux driven by the owner.
module sdram_cmd_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 12,
  parameter int BA_W      = 2,
  parameter int DQ_W      = 16,
  parameter int MAX_GRANT = 1024
) (
  input  logic                 sclk,
  input  logic                 s_rst,
  sdram_cmd_arbiter_if.master  bus
);

  localparam int GID_W = gid_w(NUM_CH);
  localparam int CNT_W = $clog2(MAX_GRANT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_GRANT - 1);

  arb_state_t          state, state_nxt;
  logic [GID_W-1:0]    grant_id, rr_ptr, pick_idx;
  logic [CNT_W-1:0]    grant_cnt;
  logic                pick_vld;
  logic                ref_now, grant_now, expire, cnt_last;
  logic                ref_en, timeout_err;
  logic [NUM_CH-1:0]   ch_en, grant_oh;

  logic [CMD_W-1:0]    pin_cmd;
  logic [ADDR_W-1:0]   pin_addr;
  logic [BA_W-1:0]     pin_bank;
  logic [DQ_W-1:0]     pin_dq;
  logic                pin_oe;

  sdram_rr_pick #(.N(NUM_CH), .IW(GID_W)) u_pick (
    .req (bus.ch_req),
    .ptr (rr_ptr),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  assign cnt_last = (grant_cnt == CNT_LAST);
  assign grant_oh = NUM_CH'(1) << pick_idx;

  // State register
  always_ff @(posedge sclk) begin
    if (s_rst) state <= ST_INIT;
    else       state <= state_nxt;
  end

  // Next state; an end pulse wins over a watchdog expiry in the same cycle
  always_comb begin
    state_nxt = state;
    ref_now   = 1'b0;
    grant_now = 1'b0;
    expire    = 1'b0;
    case (state)
      ST_INIT:  if (bus.init_done) state_nxt = ST_ARBIT;
      ST_ARBIT: begin
        if (bus.ref_req) begin
          state_nxt = ST_AREF;
          ref_now   = 1'b1;
        end else if (pick_vld) begin
          state_nxt = ST_GRANT;
          grant_now = 1'b1;
        end
      end
      ST_AREF: begin
        if (bus.ref_end) begin
          state_nxt = ST_ARBIT;
        end else if (cnt_last) begin
          state_nxt = ST_ARBIT;
          expire    = 1'b1;
        end
      end
      ST_GRANT: begin
        if (bus.ch_end[grant_id]) begin
          state_nxt = ST_ARBIT;
        end else if (cnt_last) begin
          state_nxt = ST_ARBIT;
          expire    = 1'b1;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Grant pulses, owner/pointer bookkeeping, watchdog counter and sticky flag
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      ref_en      <= 1'b0;
      ch_en       <= '0;
      grant_id    <= '0;
      rr_ptr      <= '0;
      grant_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      ref_en <= ref_now;
      ch_en  <= grant_now ? grant_oh : '0;
      if (grant_now) begin
        grant_id <= pick_idx;
        rr_ptr   <= (pick_idx == GID_W'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
      end
      if (ref_now || grant_now)
        grant_cnt <= '0;
      else if (state == ST_AREF || state == ST_GRANT)
        grant_cnt <= grant_cnt + 1'b1;
      if (expire) timeout_err <= 1'b1;
    end
  end

  // Pin mux from the registered owner; idle states drive NOP with DQ released
  always_comb begin
    pin_cmd  = CMD_NOP;
    pin_addr = '0;
    pin_bank = '0;
    pin_dq   = '0;
    pin_oe   = 1'b0;
    case (state)
      ST_INIT: begin
        pin_cmd  = bus.init_cmd;
        pin_addr = bus.init_addr;
      end
      ST_AREF: begin
        pin_cmd  = bus.ref_cmd;
        pin_addr = bus.ref_addr;
      end
      ST_GRANT: begin
        pin_cmd  = bus.ch_cmd[grant_id];
        pin_addr = bus.ch_addr[grant_id];
        pin_bank = bus.ch_bank[grant_id];
        pin_dq   = bus.ch_wdata[grant_id];
        pin_oe   = bus.ch_dq_oe[grant_id];
      end
      default: ;
    endcase
  end

  assign bus.sdram_cmd    = pin_cmd;
  assign bus.sdram_addr   = pin_addr;
  assign bus.sdram_bank   = pin_bank;
  assign bus.sdram_dq_out = pin_dq;
  assign bus.sdram_dq_oe  = pin_oe;
  assign bus.sdram_dqm    = '0;
  assign bus.ref_en       = ref_en;
  assign bus.ch_en        = ch_en;
  assign bus.grant_id     = grant_id;
  assign bus.busy         = (state != ST_ARBIT);
  assign bus.timeout_err  = timeout_err;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed bench for sdram_cmd_arbiter: init timing, round-robin order,
// refresh priority, DQ enable, watchdog and mid-burst reset.
module tb_sdram_cmd_arbiter;

  localparam int NCH = 4;
  localparam logic [3:0]  NOP   = 4'b0111;
  localparam logic [3:0]  ICMD  = 4'b0010;
  localparam logic [11:0] IADDR = 12'h400;
  localparam logic [3:0]  RCMD  = 4'b0001;
  localparam logic [11:0] RADDR = 12'h0AB;

  logic sclk, s_rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  sdram_cmd_arbiter_if #(.NUM_CH(NCH), .ADDR_W(12), .BA_W(2), .DQ_W(16)) bus ();

  sdram_cmd_arbiter #(
    .NUM_CH(NCH), .ADDR_W(12), .BA_W(2), .DQ_W(16), .MAX_GRANT(16)
  ) dut (
    .sclk  (sclk),
    .s_rst (s_rst),
    .bus   (bus)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  typedef struct {
    logic        ref_req, ref_end;
    logic [3:0]  ch_req, ch_end;
    logic [3:0]  e_cmd;
    logic [11:0] e_addr;
    logic [1:0]  e_bank;
    logic        e_busy, e_ref_en;
    logic [3:0]  e_ch_en;
    logic [1:0]  e_gid;
    logic        e_oe;
    logic [15:0] e_dq;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic rq, logic re, logic [3:0] cr, logic [3:0] ce,
                              logic [3:0] cmd, logic [11:0] a, logic [1:0] b,
                              logic bz, logic ren, logic [3:0] en, logic [1:0] g,
                              logic oe, logic [15:0] dq);
    vec_t v;
    v.ref_req = rq;  v.ref_end = re;  v.ch_req = cr;  v.ch_end = ce;
    v.e_cmd = cmd;   v.e_addr = a;    v.e_bank = b;   v.e_busy = bz;
    v.e_ref_en = ren; v.e_ch_en = en; v.e_gid = g;    v.e_oe = oe;
    v.e_dq = dq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Reset, then one cycle of init_done so the arbiter sits in ARBIT
  task automatic do_reset();
    s_rst = 1'b1;
    bus.init_done = 1'b0;
    bus.ch_req = '0; bus.ch_end = '0; bus.ref_req = 1'b0; bus.ref_end = 1'b0;
    repeat (3) tick();
    s_rst = 1'b0;
    bus.init_done = 1'b1;
    tick();
  endtask

  function automatic int oh_idx(logic [3:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < NCH; i++) if (oh[i]) r = i;
    return r;
  endfunction

  initial begin
    int order[5];
    int got, since, owner;
    bit in_burst, gap_chk;

    // Static client/sequencer data; ch2 is the only writer
    bus.init_cmd  = ICMD;  bus.init_addr = IADDR;
    bus.ref_cmd   = RCMD;  bus.ref_addr  = RADDR;
    for (int k = 0; k < NCH; k++) begin
      bus.ch_cmd[k]   = 4'(8 + k);
      bus.ch_addr[k]  = 12'(256 * (k + 1));
      bus.ch_bank[k]  = 2'(k);
      bus.ch_wdata[k] = 16'(16'h1111 * (k + 1));
    end
    bus.ch_wdata[2] = 16'hA5C3;
    bus.ch_dq_oe    = 4'b0100;

    // ---- reset state and init timing
    s_rst = 1'b1;
    bus.init_done = 1'b0;
    bus.ch_req = '0; bus.ch_end = '0; bus.ref_req = 1'b0; bus.ref_end = 1'b0;
    repeat (3) tick();
    check("rst_busy",   32'(bus.busy), 32'd1);
    check("rst_ref_en", 32'(bus.ref_en), 32'd0);
    check("rst_ch_en",  32'(bus.ch_en), 32'd0);
    check("rst_gid",    32'(bus.grant_id), 32'd0);
    check("rst_tmo",    32'(bus.timeout_err), 32'd0);
    check("rst_cmd",    32'(bus.sdram_cmd), 32'(ICMD));
    check("rst_addr",   32'(bus.sdram_addr), 32'(IADDR));
    check("rst_oe",     32'(bus.sdram_dq_oe), 32'd0);
    check("rst_dqm",    32'(bus.sdram_dqm), 32'd0);
    s_rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 20) bus.init_done = 1'b1;
      check($sformatf("init_c%0d_cmd", c), 32'(bus.sdram_cmd), 32'(ICMD));
      check($sformatf("init_c%0d_busy", c), 32'(bus.busy), 32'd1);
    end
    tick();
    check("init_c21_cmd",  32'(bus.sdram_cmd), 32'(NOP));
    check("init_c21_busy", 32'(bus.busy), 32'd0);

    // ---- round robin with all four requesting, each ending 5 cycles after en
    got = 0; since = 0; owner = 0; in_burst = 0; gap_chk = 0;
    for (int i = 0; i < 5; i++) order[i] = -1;
    bus.ch_req = 4'hF;
    for (int cyc = 0; cyc < 200 && got < 5; cyc++) begin
      tick();
      if (gap_chk) begin
        check("rr_gap_cmd",  32'(bus.sdram_cmd), 32'(NOP));
        check("rr_gap_busy", 32'(bus.busy), 32'd0);
        gap_chk = 0;
      end
      bus.ch_end = '0;
      if (bus.ch_en != 4'b0) begin
        owner = oh_idx(bus.ch_en);
        order[got] = owner;
        got++;
        in_burst = 1; since = 0;
        check("rr_first_cmd", 32'(bus.sdram_cmd), 32'(8 + owner));
      end else if (in_burst) begin
        since++;
        if (since == 5) begin
          bus.ch_end[owner] = 1'b1;
          in_burst = 0; gap_chk = 1;
        end
      end
    end
    check("rr_grants_seen", 32'(got), 32'd5);
    for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % NCH));

    // ---- table-driven sequence, starting from ARBIT with rr_ptr=0
    //            rq re cr       ce       cmd   addr    bk  bz ren en      g  oe dq
    tbl[0]  = mk(0, 0, 4'b0010, 4'b0000, 4'h9, 12'h200, 1, 1, 0, 4'b0010, 1, 0, 16'h0);
    tbl[1]  = mk(0, 0, 4'b0010, 4'b0000, 4'h9, 12'h200, 1, 1, 0, 4'b0000, 1, 0, 16'h0);
    tbl[2]  = mk(0, 0, 4'b0010, 4'b0001, 4'h9, 12'h200, 1, 1, 0, 4'b0000, 1, 0, 16'h0);
    tbl[3]  = mk(0, 0, 4'b0000, 4'b0010, NOP,  12'h000, 0, 0, 0, 4'b0000, 1, 0, 16'h0);
    tbl[4]  = mk(0, 0, 4'b0011, 4'b0000, 4'h8, 12'h100, 0, 1, 0, 4'b0001, 0, 0, 16'h0);
    tbl[5]  = mk(0, 0, 4'b0000, 4'b0001, NOP,  12'h000, 0, 0, 0, 4'b0000, 0, 0, 16'h0);
    tbl[6]  = mk(0, 0, 4'b0011, 4'b0000, 4'h9, 12'h200, 1, 1, 0, 4'b0010, 1, 0, 16'h0);
    tbl[7]  = mk(0, 0, 4'b0000, 4'b0010, NOP,  12'h000, 0, 0, 0, 4'b0000, 1, 0, 16'h0);
    tbl[8]  = mk(0, 1, 4'b0000, 4'b0000, NOP,  12'h000, 0, 0, 0, 4'b0000, 1, 0, 16'h0);
    tbl[9]  = mk(1, 0, 4'b0010, 4'b0000, RCMD, RADDR,   0, 1, 1, 4'b0000, 1, 0, 16'h0);
    tbl[10] = mk(0, 0, 4'b0010, 4'b0000, RCMD, RADDR,   0, 1, 0, 4'b0000, 1, 0, 16'h0);
    tbl[11] = mk(0, 1, 4'b0010, 4'b0000, NOP,  12'h000, 0, 0, 0, 4'b0000, 1, 0, 16'h0);
    tbl[12] = mk(0, 0, 4'b0010, 4'b0000, 4'h9, 12'h200, 1, 1, 0, 4'b0010, 1, 0, 16'h0);
    tbl[13] = mk(0, 0, 4'b0000, 4'b0010, NOP,  12'h000, 0, 0, 0, 4'b0000, 1, 0, 16'h0);
    tbl[14] = mk(0, 0, 4'b0100, 4'b0000, 4'hA, 12'h300, 2, 1, 0, 4'b0100, 2, 1, 16'hA5C3);
    tbl[15] = mk(0, 0, 4'b0000, 4'b0001, 4'hA, 12'h300, 2, 1, 0, 4'b0000, 2, 1, 16'hA5C3);
    tbl[16] = mk(0, 0, 4'b0000, 4'b0100, NOP,  12'h000, 0, 0, 0, 4'b0000, 2, 0, 16'h0);
    tbl[17] = mk(0, 0, 4'b1001, 4'b0000, 4'hB, 12'h400, 3, 1, 0, 4'b1000, 3, 0, 16'h0);
    tbl[18] = mk(0, 0, 4'b0000, 4'b1000, NOP,  12'h000, 0, 0, 0, 4'b0000, 3, 0, 16'h0);
    tbl[19] = mk(0, 0, 4'b1001, 4'b0000, 4'h8, 12'h100, 0, 1, 0, 4'b0001, 0, 0, 16'h0);
    tbl[20] = mk(0, 0, 4'b0000, 4'b0001, NOP,  12'h000, 0, 0, 0, 4'b0000, 0, 0, 16'h0);

    do_reset();
    check("arbit_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 21; i++) begin
      bus.ref_req = tbl[i].ref_req;
      bus.ref_end = tbl[i].ref_end;
      bus.ch_req  = tbl[i].ch_req;
      bus.ch_end  = tbl[i].ch_end;
      tick();
      check($sformatf("v%0d_cmd", i),    32'(bus.sdram_cmd),   32'(tbl[i].e_cmd));
      check($sformatf("v%0d_addr", i),   32'(bus.sdram_addr),  32'(tbl[i].e_addr));
      check($sformatf("v%0d_bank", i),   32'(bus.sdram_bank),  32'(tbl[i].e_bank));
      check($sformatf("v%0d_busy", i),   32'(bus.busy),        32'(tbl[i].e_busy));
      check($sformatf("v%0d_ref_en", i), 32'(bus.ref_en),      32'(tbl[i].e_ref_en));
      check($sformatf("v%0d_ch_en", i),  32'(bus.ch_en),       32'(tbl[i].e_ch_en));
      check($sformatf("v%0d_gid", i),    32'(bus.grant_id),    32'(tbl[i].e_gid));
      check($sformatf("v%0d_oe", i),     32'(bus.sdram_dq_oe), 32'(tbl[i].e_oe));
      if (tbl[i].e_oe)
        check($sformatf("v%0d_dq", i),   32'(bus.sdram_dq_out), 32'(tbl[i].e_dq));
    end
    bus.ch_end = '0; bus.ref_end = 1'b0; bus.ch_req = '0;

    // ---- watchdog: client 0 never ends, MAX_GRANT=16
    bus.ch_req = 4'b0001;
    tick();
    check("wd_grant", 32'(bus.ch_en), 32'b0001);
    bus.ch_req = '0;
    for (int t = 1; t <= 15; t++) tick();
    check("wd_last_busy", 32'(bus.busy), 32'd1);
    check("wd_last_tmo",  32'(bus.timeout_err), 32'd0);
    tick();
    check("wd_exp_busy", 32'(bus.busy), 32'd0);
    check("wd_exp_cmd",  32'(bus.sdram_cmd), 32'(NOP));
    check("wd_exp_tmo",  32'(bus.timeout_err), 32'd1);
    repeat (3) tick();
    check("wd_sticky", 32'(bus.timeout_err), 32'd1);
    bus.ch_req = 4'b0010;
    tick();
    check("wd_next_en",  32'(bus.ch_en), 32'b0010);
    check("wd_next_gid", 32'(bus.grant_id), 32'd1);
    bus.ch_req = '0; bus.ch_end = 4'b0010;
    tick();
    bus.ch_end = '0;
    check("wd_next_done", 32'(bus.busy), 32'd0);
    check("wd_sticky2",   32'(bus.timeout_err), 32'd1);

    // ---- reset in the middle of a write burst
    bus.ch_req = 4'b0100;
    tick();
    bus.ch_req = '0;
    tick();
    check("mid_oe", 32'(bus.sdram_dq_oe), 32'd1);
    s_rst = 1'b1;
    tick();
    check("mrst_busy", 32'(bus.busy), 32'd1);
    check("mrst_oe",   32'(bus.sdram_dq_oe), 32'd0);
    check("mrst_tmo",  32'(bus.timeout_err), 32'd0);
    check("mrst_cmd",  32'(bus.sdram_cmd), 32'(ICMD));
    check("mrst_gid",  32'(bus.grant_id), 32'd0);

    // ---- end pulse in the expiry cycle is a normal end
    do_reset();
    bus.ch_req = 4'b0001;
    tick();
    bus.ch_req = '0;
    for (int t = 1; t <= 15; t++) tick();
    bus.ch_end = 4'b0001;
    tick();
    bus.ch_end = '0;
    check("tie_busy", 32'(bus.busy), 32'd0);
    check("tie_tmo",  32'(bus.timeout_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
